dct_1d_stream: RTL and testbench
================================

Name: dct_1d_stream

Overview:
- Parametrised, time-multiplexed 1D DCT-II / inverse DCT engine.
- Successor to the fixed 8-point parallel systolic 1D DCT.
- Accepts an N-sample block serially on a valid/ready stream and computes each coefficient with a single MAC against a run-time-loadable coefficient memory.
- Emits N results serially with backpressure. Intended as the row/column engine for the streaming 2D DCT.

Parameters:
N, 8, transform length; allowed values 4, 8, 16
DATA_WIDTH, 16, input sample width, signed Q1.(DATA_WIDTH-1)
COEF_WIDTH, 16, coefficient width, signed Q1.(COEF_WIDTH-1)
OUT_WIDTH, 16, output width, signed
OUT_FRAC, 12, output fractional bits (default gives Q3.12)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
mode  in  1  0 = forward DCT, 1 = inverse DCT; latched with the first sample of each block
in_valid  in  1  input sample valid
in_ready  out  1  engine can accept a sample
in_data  in  DATA_WIDTH  input sample
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  OUT_WIDTH  result X[k]
out_last  out  1  high with the k=N-1 result
coef_we  in  1  coefficient write strobe
coef_addr  in  2*log2(N)  address = row*N + col, i.e. C[k][n]
coef_data  in  COEF_WIDTH  coefficient value

Behaviour:
- Reset (rst low, asynchronous):
  - state=LOAD, sample count=0, k=0, n=0, accumulator=0.
  - in_ready=0, out_valid=0, out_data=0, out_last=0.
  - Coefficient memory is not reset and retains its contents.
  - in_ready rises on the first clk edge after rst deasserts.
- Reset mid-operation aborts the block; partial outputs are discarded.
- LOAD state:
  - in_ready=1. Each in_valid&in_ready handshake stores in_data into sample buffer x[count] and increments count.
  - mode is latched on the handshake with count=0.
  - On the handshake with count=N-1: in_ready drops next cycle, count clears, k=0, n=0, acc=0, state goes to CALC.
- CALC state:
  - One MAC per cycle. Forward: acc += x[n]*C[k][n]. Inverse: acc += x[n]*C[n][k].
  - After the n=N-1 MAC (the N-th CALC edge), the rounded, saturated result is registered into out_data, out_valid=1, out_last=(k==N-1), and state goes to EMIT.
  - Latency: out_valid rises N cycles after the edge that accepted the last sample.
- EMIT state:
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
  - On the out_valid&out_ready edge, out_valid drops.
  - If k==N-1, state goes to LOAD. Otherwise k increments, acc and n clear, and state goes to CALC.
- Throughput with out_ready=1: N load cycles plus N*(N+1) compute/emit cycles per block.
- Arithmetic:
  - Products are full precision, DATA_WIDTH+COEF_WIDTH bits.
  - Accumulator is DATA_WIDTH+COEF_WIDTH+log2(N) bits and cannot overflow.
  - Rescale: S = DATA_WIDTH+COEF_WIDTH-2-OUT_FRAC. Add 2^(S-1) (round half up), then arithmetic-shift right by S.
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Coefficient writes:
  - Honoured only in LOAD state with count=0; a write in any other condition is ignored.
  - A write becomes visible to the next block.
- Simultaneous coef_we and the first in_valid handshake: the write is honoured and the sample is accepted.
- mode changes after the first sample of a block have no effect on that block.
- in_valid while in_ready=0 is ignored; the sample is not consumed.

Test Plan:
- N=8, DW=CW=OUT=16, OUT_FRAC=12, memory loaded with the orthonormal DCT-II matrix in Q1.15 (row 0 = 11585). Drive 8 samples of 16384 in forward mode -> out_data 5793 for k=0 and 0±1 for k=1..7; out_last only on the 8th result; out_valid rises exactly 8 cycles after the last input edge.
- Same setup, inverse mode, input [11585,0,0,0,0,0,0,0] -> all 8 outputs 512±1.
- Forward impulse x[7]=32767, others 0 -> X[k] = round(C[k][7]*4096/32768)±1 for each k, e.g. X[0]=1448.
- Instance with OUT_FRAC=13, all coefficients 32767:
  - inputs all 32767 -> every output 32767 (saturated);
  - inputs all -32768 -> every output -32768.
- Backpressure: hold out_ready=0 for 5 cycles while out_valid=1 -> out_data and out_last stable, in_ready=0, no result lost; next result arrives N+1 cycles after release.
- Coefficient write during CALC plus reset mid-CALC:
  - The write is ignored; the current block's results are unchanged.
  - Asserting rst low at n=3 forces out_valid=0 and in_ready=0 immediately.
  - After release, a fresh 8-sample block produces correct results with the previously loaded coefficients.

Source files
------------

// File: rtl/dct_1d_stream.sv
// Time-multiplexed N-point 1D DCT-II / inverse DCT: serial sample load, one MAC
// per cycle against a run-time-loadable coefficient matrix, serial result emit.
module dct_1d_stream #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int OUT_FRAC   = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         out_last,
    input  logic                         coef_we,
    input  logic [2*$clog2(N)-1:0]       coef_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_data
);
    localparam int LOGN   = $clog2(N);
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W  = PROD_W + LOGN;
    localparam int SHIFT  = DATA_WIDTH + COEF_WIDTH - 2 - OUT_FRAC;

    localparam logic [LOGN-1:0]       LAST_IDX = LOGN'(N - 1);
    localparam logic signed [ACC_W:0] RND_HALF = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [ACC_W:0] OUT_MAX  = {{(ACC_W + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN  = {{(ACC_W + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {LOAD, CALC, EMIT} state_t;

    // Round half up at the output LSB, then clamp to the signed output range.
    function automatic logic signed [OUT_WIDTH-1:0] round_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] r;
        r = $signed({a[ACC_W-1], a}) + RND_HALF;
        r = r >>> SHIFT;
        if (r > OUT_MAX) return OUT_MAX[OUT_WIDTH-1:0];
        if (r < OUT_MIN) return OUT_MIN[OUT_WIDTH-1:0];
        return r[OUT_WIDTH-1:0];
    endfunction

    state_t                       state;
    logic [LOGN-1:0]              cnt;
    logic [LOGN-1:0]              k_idx;
    logic [LOGN-1:0]              n_idx;
    logic                         mode_q;
    logic signed [ACC_W-1:0]      acc;
    logic signed [DATA_WIDTH-1:0] x_buf    [N];
    logic signed [COEF_WIDTH-1:0] coef_mem [N*N];

    logic                         take;
    logic [2*LOGN-1:0]            rd_addr;
    logic signed [COEF_WIDTH-1:0] coef_rd;
    logic signed [PROD_W-1:0]     prod;
    logic signed [ACC_W-1:0]      acc_sum;

    // in_ready is only ever high in LOAD, so a handshake implies LOAD.
    assign take    = in_valid && in_ready;
    // Inverse transform walks the transposed matrix: C[n][k] instead of C[k][n].
    assign rd_addr = mode_q ? {n_idx, k_idx} : {k_idx, n_idx};
    assign coef_rd = coef_mem[rd_addr];
    assign prod    = PROD_W'(x_buf[n_idx]) * PROD_W'(coef_rd);
    assign acc_sum = acc + ACC_W'(prod);

    // Storage is never reset; coefficients survive a reset and are only
    // writable between blocks so a running transform sees a stable matrix.
    always_ff @(posedge clk) begin
        if (coef_we && state == LOAD && cnt == '0)
            coef_mem[coef_addr] <= coef_data;
        if (take)
            x_buf[cnt] <= in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LOAD;
            cnt       <= '0;
            k_idx     <= '0;
            n_idx     <= '0;
            mode_q    <= 1'b0;
            acc       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (take) begin
                        if (cnt == '0)
                            mode_q <= mode;
                        if (cnt == LAST_IDX) begin
                            cnt      <= '0;
                            k_idx    <= '0;
                            n_idx    <= '0;
                            acc      <= '0;
                            in_ready <= 1'b0;
                            state    <= CALC;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_sum;
                    if (n_idx == LAST_IDX) begin
                        out_data  <= round_sat(acc_sum);
                        out_valid <= 1'b1;
                        out_last  <= (k_idx == LAST_IDX);
                        state     <= EMIT;
                    end else begin
                        n_idx <= n_idx + 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (k_idx == LAST_IDX) begin
                            in_ready <= 1'b1;
                            state    <= LOAD;
                        end else begin
                            k_idx <= k_idx + 1'b1;
                            n_idx <= '0;
                            acc   <= '0;
                            state <= CALC;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_dct_1d_stream.sv
// Bench for dct_1d_stream: two instances (OUT_FRAC 12 and 13) share all stimulus
// and are checked against a plain-arithmetic matrix-product reference model.
module tb_dct_1d_stream;
    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               mode;
    logic               in_valid;
    logic signed [15:0] in_data;
    logic               out_ready;
    logic               coef_we;
    logic [5:0]         coef_addr;
    logic signed [15:0] coef_data;

    logic               a_in_ready, a_out_valid, a_out_last;
    logic signed [15:0] a_out_data;
    logic               b_in_ready, b_out_valid, b_out_last;
    logic signed [15:0] b_out_data;

    dct_1d_stream #(.N(8), .DATA_WIDTH(16), .COEF_WIDTH(16), .OUT_WIDTH(16), .OUT_FRAC(12)) u_a (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data));

    dct_1d_stream #(.N(8), .DATA_WIDTH(16), .COEF_WIDTH(16), .OUT_WIDTH(16), .OUT_FRAC(13)) u_b (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data));

    int total = 0;
    int bad   = 0;

    int mc[64];
    int dct_m[64];
    int fill_m[64];
    int xs[N];
    int ra[N], rb[N];
    bit la[N], lb[N], vdrop[N];
    int gap[N];
    int lat;
    bit bp_stable, bp_low, rdy_after;

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    function automatic int rand16();
        logic signed [15:0] t;
        t = 16'($urandom);
        return int'(t);
    endfunction

    // X = C*x (forward) or C^T*x (inverse), rescaled and clamped.
    function automatic int model_out(input int k, input bit inv, input int frac);
        longint acc, one, r;
        int s;
        acc = 0;
        for (int n = 0; n < N; n++)
            acc += longint'(xs[n]) * longint'(inv ? mc[n*N + k] : mc[k*N + n]);
        s   = 30 - frac;
        one = 1;
        r   = (acc + (one <<< (s - 1))) >>> s;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic load_coefs(input int m[64]);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            coef_we   = 1'b1;
            coef_addr = 6'(i);
            coef_data = 16'(m[i]);
            mc[i]     = m[i];
        end
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic load_samples(input bit inv, input bit wr_first, input int wr_addr, input int wr_val);
        int guard;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 16'(xs[i]);
            mode     = (i == 0) ? inv : ~inv;
            if (i == 0 && wr_first) begin
                coef_we   = 1'b1;
                coef_addr = 6'(wr_addr);
                coef_data = 16'(wr_val);
            end
            guard = 0;
            while (!a_in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) begin
                total++; bad++;
                $display("FAIL load_timeout sample=%0d in_ready=%b want=1", i, a_in_ready);
            end
            @(posedge clk);
            #1;
            coef_we = 1'b0;
            if (i == 0 && wr_first) mc[wr_addr] = wr_val;
        end
        in_valid = 1'b0;
        mode     = ~inv;
    endtask

    task automatic collect(input int bp_k, input bit wr_calc, input bit junk);
        int guard;
        in_valid = junk;
        in_data  = 16'($urandom);
        if (wr_calc) begin
            coef_we   = 1'b1;
            coef_addr = 6'd0;
            coef_data = -16'sd1234;
        end
        for (int k = 0; k < N; k++) begin
            guard = 0;
            while (!a_out_valid && guard < 100) begin
                @(posedge clk);
                #1;
                guard++;
                if (junk) in_data = 16'($urandom);
                if (guard == 2) coef_we = 1'b0;
            end
            if (guard >= 100) begin
                total++; bad++;
                $display("FAIL result_timeout k=%0d out_valid=%b want=1", k, a_out_valid);
            end
            if (k == 0) lat = guard;
            else gap[k] = guard + 1;
            ra[k] = int'(a_out_data);
            rb[k] = int'(b_out_data);
            la[k] = a_out_last;
            lb[k] = b_out_last;
            if (k == N - 1) in_valid = 1'b0;
            if (k == bp_k) begin
                bp_stable = 1'b1;
                bp_low    = 1'b1;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    if (a_out_valid !== 1'b1 || int'(a_out_data) != ra[k] || a_out_last !== la[k] ||
                        int'(b_out_data) != rb[k])
                        bp_stable = 1'b0;
                    if (a_in_ready !== 1'b0) bp_low = 1'b0;
                end
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            vdrop[k] = !a_out_valid;
        end
        rdy_after = a_in_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        total++;
        if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || a_out_data !== 16'sd0 || a_out_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%b vld=%b data=%0d last=%b want all 0",
                     a_in_ready, a_out_valid, a_out_data, a_out_last);
        end
        total++;
        if (b_in_ready !== 1'b0 || b_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs_b got rdy=%b vld=%b want 0 0", b_in_ready, b_out_valid);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (a_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_edge got=%b want=0", a_in_ready);
        end
        @(posedge clk);
        #1;
        total++;
        if (a_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_edge got=%b want=1", a_in_ready);
        end
    endtask

    task automatic test_forward_dc();
        load_coefs(dct_m);
        for (int i = 0; i < N; i++) xs[i] = 16384;
        load_samples(1'b0, 1'b0, 0, 0);
        collect(-1, 1'b0, 1'b0);
        total++;
        if (lat != N) begin
            bad++;
            $display("FAIL fwd_latency got=%0d want=%0d", lat, N);
        end
        for (int k = 0; k < N; k++) begin
            int want;
            want = (k == 0) ? 5793 : 0;
            total++;
            if (ra[k] - want > 1 || want - ra[k] > 1) begin
                bad++;
                $display("FAIL fwd_dc k=%0d got=%0d want=%0d+-1", k, ra[k], want);
            end
            total++;
            if (la[k] !== (k == N - 1)) begin
                bad++;
                $display("FAIL fwd_last k=%0d got=%b want=%b", k, la[k], k == N - 1);
            end
            total++;
            if (ra[k] != model_out(k, 1'b0, 12) || rb[k] != model_out(k, 1'b0, 13)) begin
                bad++;
                $display("FAIL fwd_model k=%0d got=%0d/%0d want=%0d/%0d", k, ra[k], rb[k],
                         model_out(k, 1'b0, 12), model_out(k, 1'b0, 13));
            end
        end
        total++;
        if (rdy_after !== 1'b1) begin
            bad++;
            $display("FAIL fwd_ready_after got=%b want=1", rdy_after);
        end
    endtask

    task automatic test_inverse();
        for (int i = 0; i < N; i++) xs[i] = 0;
        xs[0] = 11585;
        load_samples(1'b1, 1'b0, 0, 0);
        collect(-1, 1'b0, 1'b0);
        for (int k = 0; k < N; k++) begin
            total++;
            if (ra[k] - 512 > 1 || 512 - ra[k] > 1 || ra[k] != model_out(k, 1'b1, 12)) begin
                bad++;
                $display("FAIL inv_dc k=%0d got=%0d want=512+-1 model=%0d", k, ra[k], model_out(k, 1'b1, 12));
            end
        end
    endtask

    task automatic test_impulse();
        for (int i = 0; i < N; i++) xs[i] = 0;
        xs[7] = 32767;
        load_samples(1'b0, 1'b0, 0, 0);
        collect(-1, 1'b0, 1'b0);
        for (int k = 0; k < N; k++) begin
            int want;
            want = rnd(real'(dct_m[k*N + 7]) * 4096.0 / 32768.0);
            total++;
            if (ra[k] - want > 1 || want - ra[k] > 1 || ra[k] != model_out(k, 1'b0, 12)) begin
                bad++;
                $display("FAIL impulse k=%0d got=%0d want=%0d+-1", k, ra[k], want);
            end
        end
        total++;
        if (ra[0] - 1448 > 1 || 1448 - ra[0] > 1) begin
            bad++;
            $display("FAIL impulse_x0 got=%0d want=1448", ra[0]);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < N; i++) xs[i] = rand16();
        load_samples(1'b0, 1'b0, 0, 0);
        collect(3, 1'b0, 1'b0);
        total++;
        if (bp_stable !== 1'b1 || bp_low !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold got stable=%b ready_low=%b want 1 1", bp_stable, bp_low);
        end
        total++;
        if (gap[4] != N + 1) begin
            bad++;
            $display("FAIL bp_gap got=%0d want=%0d", gap[4], N + 1);
        end
        for (int k = 0; k < N; k++) begin
            total++;
            if (ra[k] != model_out(k, 1'b0, 12) || vdrop[k] !== 1'b1) begin
                bad++;
                $display("FAIL bp_result k=%0d got=%0d drop=%b want=%0d drop=1", k, ra[k], vdrop[k],
                         model_out(k, 1'b0, 12));
            end
        end
    endtask

    task automatic test_coef_write_calc();
        for (int i = 0; i < N; i++) xs[i] = rand16();
        xs[0] = 30000;
        load_samples(1'b0, 1'b0, 0, 0);
        collect(-1, 1'b1, 1'b1);
        for (int k = 0; k < N; k++) begin
            total++;
            if (ra[k] != model_out(k, 1'b0, 12) || rb[k] != model_out(k, 1'b0, 13)) begin
                bad++;
                $display("FAIL calc_write k=%0d got=%0d/%0d want=%0d/%0d", k, ra[k], rb[k],
                         model_out(k, 1'b0, 12), model_out(k, 1'b0, 13));
            end
        end
        // The ignored write must not surface in the following block either.
        for (int i = 0; i < N; i++) xs[i] = rand16();
        xs[0] = -25000;
        load_samples(1'b0, 1'b0, 0, 0);
        collect(-1, 1'b0, 1'b0);
        total++;
        if (ra[0] != model_out(0, 1'b0, 12)) begin
            bad++;
            $display("FAIL calc_write_next got=%0d want=%0d", ra[0], model_out(0, 1'b0, 12));
        end
    endtask

    task automatic test_reset_mid_calc();
        int guard;
        for (int i = 0; i < N; i++) xs[i] = rand16();
        load_samples(1'b0, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        total++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_calc got vld=%b rdy=%b want 0 0", a_out_valid, a_in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        // Second abort, this time while a result is held by backpressure.
        load_samples(1'b0, 1'b0, 0, 0);
        guard = 0;
        while (!a_out_valid && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        total++;
        if (a_out_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_emit_setup got vld=%b want=1", a_out_valid);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (a_out_valid !== 1'b0 || a_out_data !== 16'sd0 || a_out_last !== 1'b0 || a_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_emit got vld=%b data=%0d last=%b rdy=%b want 0 0 0 0",
                     a_out_valid, a_out_data, a_out_last, a_in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N; i++) xs[i] = rand16();
        load_samples(1'b1, 1'b0, 0, 0);
        collect(-1, 1'b0, 1'b0);
        for (int k = 0; k < N; k++) begin
            total++;
            if (ra[k] != model_out(k, 1'b1, 12) || la[k] !== (k == N - 1)) begin
                bad++;
                $display("FAIL rst_fresh k=%0d got=%0d last=%b want=%0d", k, ra[k], la[k], model_out(k, 1'b1, 12));
            end
        end
    endtask

    task automatic test_random_blocks();
        int old_c, new_c;
        for (int i = 0; i < 64; i++) fill_m[i] = rand16();
        load_coefs(fill_m);
        // Write alongside the first sample; x[3]=0 keeps this block's result
        // independent of C[2][3], the next block then depends on it.
        for (int i = 0; i < N; i++) xs[i] = rand16();
        xs[3] = 0;
        old_c = mc[19];
        new_c = (old_c > 0) ? old_c - 7000 : old_c + 7000;
        load_samples(1'b0, 1'b1, 19, new_c);
        collect(-1, 1'b0, 1'b0);
        for (int k = 0; k < N; k++) begin
            total++;
            if (ra[k] != model_out(k, 1'b0, 12)) begin
                bad++;
                $display("FAIL simul_write k=%0d got=%0d want=%0d", k, ra[k], model_out(k, 1'b0, 12));
            end
        end
        for (int b = 0; b < 6; b++) begin
            bit inv;
            inv = (b == 0) ? 1'b0 : 1'($urandom);
            for (int i = 0; i < N; i++) xs[i] = rand16();
            if (b == 0) xs[3] = 20000;
            load_samples(inv, 1'b0, 0, 0);
            collect(-1, 1'b0, 1'b0);
            for (int k = 0; k < N; k++) begin
                total++;
                if (ra[k] != model_out(k, inv, 12) || rb[k] != model_out(k, inv, 13) || lb[k] !== (k == N - 1)) begin
                    bad++;
                    $display("FAIL random blk=%0d inv=%0d k=%0d got=%0d/%0d want=%0d/%0d", b, inv, k,
                             ra[k], rb[k], model_out(k, inv, 12), model_out(k, inv, 13));
                end
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 64; i++) fill_m[i] = 32767;
        load_coefs(fill_m);
        for (int pass = 0; pass < 2; pass++) begin
            int want;
            want = (pass == 0) ? 32767 : -32768;
            for (int i = 0; i < N; i++) xs[i] = want;
            load_samples(1'b0, 1'b0, 0, 0);
            collect(-1, 1'b0, 1'b0);
            for (int k = 0; k < N; k++) begin
                total++;
                if (rb[k] != want) begin
                    bad++;
                    $display("FAIL saturate pass=%0d k=%0d got=%0d want=%0d", pass, k, rb[k], want);
                end
                total++;
                if (ra[k] != model_out(k, 1'b0, 12)) begin
                    bad++;
                    $display("FAIL saturate_a pass=%0d k=%0d got=%0d want=%0d", pass, k, ra[k], model_out(k, 1'b0, 12));
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog sim_time=%0t want finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < N; k++)
            for (int n = 0; n < N; n++) begin
                real a;
                a = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
                dct_m[k*N + n] = rnd(32768.0 * a * $cos(real'((2*n + 1) * k) * 3.14159265358979 / 16.0));
            end
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;

        test_reset();
        test_forward_dc();
        test_inverse();
        test_impulse();
        test_backpressure();
        test_coef_write_calc();
        test_reset_mid_calc();
        test_random_blocks();
        test_saturation();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
